// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: instruction field
// layout, the NOP opcode and the dispatch state encoding.
package dispatch_pkg;

  localparam int INSTR_W = 24;
  localparam int TAG_W   = 8;

  localparam int OPC_HI = 23;
  localparam int OPC_LO = 16;
  localparam int OP1_HI = 15;
  localparam int OP1_LO = 8;
  localparam int OP2_HI = 7;
  localparam int OP2_LO = 0;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {tag, instruction} entries. The caller only
// pushes when not full (or when popping in the same cycle) and only pops
// when not empty; pointers wrap naturally because DEPTH is a power of two.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: deduplicates the loader's held write stream,
// buffers instructions with their slot tag, and hands each one exactly
// once to a processor core chosen round-robin among ready cores.
// Optional build macro DISPATCH_SKIP_NOP_EN: new writes carrying the NOP
// opcode are consumed by the dedup logic but never buffered.
module instruction_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int INSTR_W    = dispatch_pkg::INSTR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_addr,
  input  logic [INSTR_W-1:0]            wr_data,
  input  logic                          load_done,
  output logic                          in_ready,
  output logic [NUM_CORES-1:0]          core_valid,
  input  logic [NUM_CORES-1:0]          core_ready,
  output logic [INSTR_W-1:0]            core_instr,
  output logic [7:0]                    core_tag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          all_dispatched
);

  import dispatch_pkg::*;

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int ENT_W = INSTR_W + 8;

  state_t              state;
  logic [PTR_W-1:0]    sel;
  logic [PTR_W-1:0]    rr_ptr;
  logic [7:0]          last_addr;
  logic                have_last;
  logic                done_seen;

  logic                new_write;
  logic                is_nop;
  logic                push_req;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [PTR_W-1:0]    pick;

  // First ready core at or after ptr, wrapping around the core range.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [PTR_W-1:0]     ptr,
                                               input logic [NUM_CORES-1:0] rdy);
    logic [PTR_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && rdy[PTR_W'(idx)]) begin
        found = 1'b1;
        res   = PTR_W'(idx);
      end
    end
    return res;
  endfunction

  assign new_write = wr_en && (!have_last || (wr_addr != last_addr));

`ifdef DISPATCH_SKIP_NOP_EN
  assign is_nop = (wr_data[OPC_HI:OPC_LO] == NOP_OPCODE);
`else
  assign is_nop = 1'b0;
`endif

  assign push_req = new_write && !is_nop;
  assign pop      = (state == OFFER) && core_ready[sel];
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = push_req && (!fifo_full || pop);
  assign pick     = rr_pick(rr_ptr, core_ready);

  instr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({wr_addr, wr_data}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Last accepted slot address; only meaningful once have_last is set.
  always_ff @(posedge clk) begin
    if (new_write) last_addr <= wr_addr;
  end

  // Dispatch FSM, dedup/completion flags and registered core outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sel            <= '0;
      rr_ptr         <= '0;
      core_valid     <= '0;
      core_instr     <= '0;
      core_tag       <= '0;
      have_last      <= 1'b0;
      done_seen      <= 1'b0;
      overflow       <= 1'b0;
      all_dispatched <= 1'b0;
    end else begin
      if (new_write) have_last <= 1'b1;
      if (load_done) done_seen <= 1'b1;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      all_dispatched <= done_seen && fifo_empty && (state == IDLE);

      case (state)
        IDLE: begin
          if (!fifo_empty && (|core_ready)) begin
            sel        <= pick;
            core_valid <= NUM_CORES'(1) << pick;
            core_instr <= head[INSTR_W-1:0];
            core_tag   <= head[ENT_W-1:INSTR_W];
            state      <= OFFER;
          end
        end
        OFFER: begin
          // The offer stays up until the selected core takes it.
          if (core_ready[sel]) begin
            core_valid <= '0;
            rr_ptr     <= (sel == PTR_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Randomized and directed bench for instruction_dispatcher with a queue
// based reference model and a scoreboard monitor.
module tb_instruction_dispatcher;

  localparam int NC = 4;
  localparam int FD = 8;

`ifdef DISPATCH_SKIP_NOP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [23:0]   wr_data;
  logic          load_done;
  logic          in_ready;
  logic [NC-1:0] core_valid;
  logic [NC-1:0] core_ready;
  logic [23:0]   core_instr;
  logic [7:0]    core_tag;
  logic [3:0]    fifo_count;
  logic          overflow;
  logic          all_dispatched;

  instruction_dispatcher #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (FD),
    .INSTR_W    (24)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .load_done      (load_done),
    .in_ready       (in_ready),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .core_instr     (core_instr),
    .core_tag       (core_tag),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .all_dispatched (all_dispatched)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected FIFO contents in order of acceptance.
  logic [31:0] mq[$];
  bit          m_hl, m_ovf, m_done, m_off, m_alld, started;
  logic [7:0]  m_la;
  int          m_sel, m_rr;
  int          xfers_dut;
  logic [NC-1:0] prev_valid;
  logic [7:0]    prev_tag;
  logic [23:0]   prev_instr;

  // Monitor: after every edge advance the model and compare DUT outputs.
  initial begin
    bit          pre_empty, pre_off, alld_n, found;
    logic [31:0] ent;
    started   = 0;
    xfers_dut = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mq.delete();
        m_hl = 0; m_ovf = 0; m_done = 0; m_off = 0; m_alld = 0;
        m_rr = 0; m_sel = 0;
        started = 1;
        check("rst_instr", 32'(core_instr), 32'h0);
        check("rst_tag", 32'(core_tag), 32'h0);
      end else if (started) begin
        if ((prev_valid & core_ready) != '0) xfers_dut++;
        pre_empty = (mq.size() == 0);
        pre_off   = m_off;
        alld_n    = m_done && pre_empty && !pre_off;
        if (load_done) m_done = 1;
        if (pre_off && core_ready[m_sel]) begin
          ent = mq.pop_front();
          check("xfer", {prev_tag, prev_instr}, ent);
          m_off = 0;
          m_rr  = (m_sel + 1) % NC;
        end else if (!pre_off && !pre_empty && core_ready != '0) begin
          found = 0;
          for (int k = 0; k < NC; k++) begin
            if (!found && core_ready[(m_rr + k) % NC]) begin
              found = 1;
              m_sel = (m_rr + k) % NC;
            end
          end
          m_off = 1;
        end
        if (wr_en && (!m_hl || wr_addr != m_la)) begin
          m_hl = 1;
          m_la = wr_addr;
          if (!(SKIP && wr_data[23:16] == 8'h00)) begin
            if (mq.size() < FD) mq.push_back({wr_addr, wr_data});
            else m_ovf = 1;
          end
        end
        m_alld = alld_n;
      end
      if (started) begin
        check("core_valid", 32'(core_valid), m_off ? (32'd1 << m_sel) : 32'd0);
        if (m_off) begin
          check("offer_tag", 32'(core_tag), 32'(mq[0][31:24]));
          check("offer_instr", 32'(core_instr), 32'(mq[0][23:0]));
        end
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("in_ready", 32'(in_ready), 32'(mq.size() < FD));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("all_dispatched", 32'(all_dispatched), 32'(m_alld));
      end
      prev_valid = core_valid;
      prev_tag   = core_tag;
      prev_instr = core_instr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Loader-style write: wr_en stays high afterwards with the same address.
  task automatic wr(input logic [7:0] a, input logic [23:0] d, input int hold);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic drain(input logic [NC-1:0] rdy, input int limit);
    int n;
    core_ready = rdy;
    tick(3);
    n = 0;
    while (!(fifo_count == 0 && core_valid == '0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d valid=%b after %0d cycles", fifo_count, core_valid, n);
    end
  endtask

  initial begin
    int x0;
    logic [7:0] a;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_done = 1'b0; core_ready = '0;
    tick(2);
    reset = 1'b0;

    // Dedup: slot 1 held three cycles, then slot 2.
    wr(8'd1, 24'h010203, 3);
    wr(8'd2, 24'h040506, 1);
    tick(2);
    check("dedup_count", 32'(fifo_count), 32'd2);
    drain(4'b1111, 50);

    // Round robin over all ready cores from pointer 0.
    do_reset();
    core_ready = 4'b1111;
    for (int i = 0; i < 5; i++) wr(8'(10 + i), 24'h100000 + 24'(i), 2);
    drain(4'b1111, 60);

    // Only core 2 ready.
    do_reset();
    core_ready = 4'b0100;
    wr(8'd20, 24'h200001, 1);
    drain(4'b0100, 30);

    // Stall, fill and overflow, then release.
    do_reset();
    core_ready = 4'b0000;
    x0 = xfers_dut;
    for (int i = 0; i < 9; i++) wr(8'(30 + i), 24'h300000 + 24'(i), 1);
    tick(2);
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("sticky_ovf", 32'(overflow), 32'd1);
    drain(4'b1111, 80);
    check("delivered8", 32'(xfers_dut - x0), 32'd8);

    // Completion after load_done and two instructions.
    do_reset();
    core_ready = 4'b0000;
    @(negedge clk); load_done = 1'b1;
    @(negedge clk); load_done = 1'b0;
    wr(8'd40, 24'h400001, 1);
    wr(8'd41, 24'h400002, 1);
    drain(4'b1111, 40);
    tick(2);
    check("all_dispatched", 32'(all_dispatched), 32'd1);

    // Reset while an offer is pending.
    do_reset();
    core_ready = 4'b0000;
    wr(8'd50, 24'h500001, 1);
    tick(2);
    core_ready = 4'b0010;
    tick(1);
    core_ready = 4'b0000;
    tick(2);
    check("offer_pending", 32'(core_valid), 32'b0010);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_mid_valid", 32'(core_valid), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);

    // NOP opcode followed by a regular instruction.
    wr(8'd3, 24'h000000, 2);
    wr(8'd4, 24'h050607, 2);
    drain(4'b1111, 30);

    // Randomized traffic.
    a = 8'd60;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 299) == 0);
      load_done  = ($urandom_range(0, 49) == 0);
      core_ready = NC'($urandom);
      wr_en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) a = a + 8'($urandom_range(1, 3));
      wr_addr = a;
      wr_data = 24'($urandom);
      if ($urandom_range(0, 7) == 0) wr_data[23:16] = 8'h00;
    end
    reset = 1'b0;
    load_done = 1'b0;
    drain(4'b1111, 100);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_dispatcher.md
Name: instruction_dispatcher

Overview:
- Sits directly downstream of the instruction loader.
- Consumes the loader's 24-bit memory-write stream ({opcode, operand1, operand2}) and buffers instructions in a FIFO.
- Dispatches each instruction exactly once to one of NUM_CORES processor cores via per-core valid/ready handshake, round-robin.
- Signals when the loaded program has been fully handed out.

Parameters:
- NUM_CORES, 4, number of processor cores served (2..8).
- FIFO_DEPTH, 8, instruction buffer entries (power of two).
- INSTR_W, 24, instruction width {opcode[23:16], op1[15:8], op2[7:0]}.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  loader write_enable.
- wr_addr  in  8  loader slot address; used as instruction tag.
- wr_data  in  INSTR_W  loader data_out.
- load_done  in  1  loader done.
- in_ready  out  1  FIFO not full (status only; loader has no backpressure).
- core_valid  out  NUM_CORES  one-hot offer to the selected core.
- core_ready  in  NUM_CORES  per-core accept.
- core_instr  out  INSTR_W  instruction on shared bus.
- core_tag  out  8  wr_addr captured with the instruction.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky; an instruction was dropped.
- all_dispatched  out  1  program fully dispatched.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled only on the clk edge.
- Reset values:
  - core_valid = 0, core_instr = 0, core_tag = 0.
  - fifo_count = 0, in_ready = 1, overflow = 0, all_dispatched = 0.
  - rr_ptr = 0, state = IDLE, have_last = 0, done_seen = 0.
- Write dedup:
  - Loader holds wr_en high for several cycles per slot and after finishing. A write is new only when wr_en = 1 AND (have_last = 0 OR wr_addr != last_addr).
  - On a new write: last_addr <= wr_addr, have_last <= 1.
  - Repeated addresses are ignored; they are never overflow.
- Push and pop:
  - A new write pushes {wr_addr, wr_data}.
  - If the FIFO is full and no pop occurs the same cycle: entry dropped, overflow <= 1 (sticky until reset).
  - If the FIFO is full and a pop occurs the same cycle: push accepted, count unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count and in_ready are registered and reflect the post-edge state.
- State machine:
  - IDLE: if FIFO non-empty and any core_ready bit is 1, select the first ready core scanning from rr_ptr upward with wrap. Register sel, drive core_valid[sel] = 1, core_instr/core_tag = FIFO head, go to OFFER. Otherwise stay.
  - OFFER: hold core_valid, core_instr and core_tag stable until core_ready[sel] = 1. On that edge: pop FIFO, core_valid <= 0, rr_ptr <= (sel+1) mod NUM_CORES, return to IDLE. A ready drop does not withdraw the offer.
- Timing:
  - Max throughput is one instruction every 2 cycles.
  - Latency: new write at edge T → valid at edge T+2 earliest (T+1 FIFO visible, T+2 offer registered).
- Completion:
  - done_seen <= 1 on load_done = 1 (sticky).
  - all_dispatched = done_seen AND FIFO empty AND state = IDLE, registered.
- Reset mid-OFFER: valid drops on the reset edge; the instruction is lost, not replayed.

Optional Feature:
- Macro DISPATCH_SKIP_NOP_EN.
- When defined: new writes with opcode 8'h00 are consumed by the dedup logic but not pushed, and never set overflow.
- When undefined: opcode 00 is dispatched like any other instruction.

Decomposition:
- Shared package dispatch_pkg:
  - INSTR_W.
  - Field slice constants OPC_HI/OPC_LO, OP1_HI/OP1_LO, OP2_HI/OP2_LO.
  - NOP_OPCODE = 8'h00.
  - State enum {IDLE, OFFER}.
- Natural sub-module: instr_fifo (sync FIFO, push/pop/count/full/empty, width INSTR_W+8).
- Round-robin selection stays inline.

Test Plan:
- Dedup: wr_en held high, wr_addr = 1 for 3 cycles with data 24'h010203, then wr_addr = 2 with 24'h040506 → fifo_count goes 1 then 2; dispatched tags are 1, 2.
- Round robin: all core_ready = 4'b1111, 5 instructions pushed → core_valid sequence 0001, 0010, 0100, 1000, 0001.
- Readiness skip: core_ready = 4'b0100, rr_ptr = 0 → selects core 2; next rr_ptr = 3.
- Stall and overflow: core_ready = 0, 9 distinct writes → fifo_count = 8, in_ready = 0, overflow = 1, offer held stable. After releasing ready, exactly 8 instructions are delivered.
- Completion and reset: load_done pulse, 2 queued instructions, ready = 1 → all_dispatched = 1 after the second transfer. Reset during OFFER → core_valid = 0 and fifo_count = 0 on that edge.
- SKIP_NOP (macro defined): writes 24'h000000 at addr 3 and 24'h050607 at addr 4 → only tag 4 is dispatched.
